// File: rtl/mc_register_bank_pkg.sv
// Shared types for the mc_register_bank slice: 32-bit register word, clock/reset
// bundle, default identification word and a byte-strobe expansion helper.
package mc_register_bank_pkg;

  typedef logic [31:0] reg32_t;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  localparam reg32_t MC_ID_DEFAULT = 32'h4D43_0001;

  // Expand 4 byte strobes to a 32-bit bit mask.
  function automatic reg32_t byte_mask(input logic [3:0] we);
    reg32_t m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{we[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mc_register_bank_sticky.sv
// One 32-bit status word: MASK bits latch high until cleared by write-1, where a
// concurrent set wins; unmasked bits pass the live input straight through.
module mc_sticky_status
  import mc_register_bank_pkg::*;
#(
  parameter reg32_t MASK = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  reg32_t stat_i,
  input  reg32_t clr_i,
  output reg32_t val_o
);

  reg32_t sticky_q;
  reg32_t sticky_d;

  always_comb begin
    sticky_d = MASK & ((sticky_q & ~clr_i) | stat_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Sticky bits read the latched value, so a set in the current cycle is not visible yet.
  assign val_o = (stat_i & ~MASK) | (sticky_q & MASK);

endmodule

// File: rtl/mc_register_bank.sv
// Memory-mapped register bank: ID word, NCTRL read/write control registers with
// optional pulse bits and write strobes, NSTAT status words with optional W1C sticky bits.
module mc_register_bank
  import mc_register_bank_pkg::*;
#(
  parameter int                 NCTRL            = 4,
  parameter int                 NSTAT            = 4,
  parameter reg32_t             ID_VALUE         = MC_ID_DEFAULT,
  parameter reg32_t [NCTRL-1:0] CTRL_RST         = '0,
  parameter reg32_t [NCTRL-1:0] CTRL_PULSE_MASK  = '0,
  parameter reg32_t [NSTAT-1:0] STAT_STICKY_MASK = '0
) (
  input  ckrs_t              ClkRs_ix,
  input  logic               en,
  input  logic [31:0]        addr,
  input  logic [3:0]         we,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output reg32_t [NCTRL-1:0] ctrl_ob,
  output logic [NCTRL-1:0]   ctrl_wr_ob,
  input  reg32_t [NSTAT-1:0] stat_ib
);

  logic               clk;
  logic               rst_n;
  logic [29:0]        word_idx;
  logic               wr_en;
  logic               rd_en;
  reg32_t             wmask;
  logic               unused_addr_bits;

  reg32_t [NCTRL-1:0] ctrl_q;
  reg32_t [NCTRL-1:0] ctrl_d;
  logic   [NCTRL-1:0] ctrl_wr_q;
  logic   [NCTRL-1:0] ctrl_wr_d;
  reg32_t             dout_q;
  reg32_t             dout_d;
  reg32_t             rd_data;
  reg32_t [NSTAT-1:0] stat_val;
  reg32_t [NSTAT-1:0] stat_clr;

  assign clk              = ClkRs_ix.clk;
  assign rst_n            = ClkRs_ix.reset;
  assign word_idx         = addr[31:2];
  assign unused_addr_bits = ^addr[1:0];
  assign wr_en            = en && (we != 4'b0000);
  assign rd_en            = en && (we == 4'b0000);
  assign wmask            = byte_mask(we);

  // Pulse bits fall back to 0 every cycle unless rewritten; other bits hold.
  always_comb begin
    ctrl_d    = ctrl_q & ~CTRL_PULSE_MASK;
    ctrl_wr_d = '0;
    for (int i = 0; i < NCTRL; i++) begin
      if (wr_en && (word_idx == 30'(i + 1))) begin
        ctrl_d[i]    = (ctrl_d[i] & ~wmask) | (din & wmask);
        ctrl_wr_d[i] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTAT; gi++) begin : g_stat
      assign stat_clr[gi] = (wr_en && (word_idx == 30'(NCTRL + 1 + gi))) ? (din & wmask) : '0;

      mc_sticky_status #(
        .MASK (STAT_STICKY_MASK[gi])
      ) u_sticky (
        .clk    (clk),
        .rst_n  (rst_n),
        .stat_i (stat_ib[gi]),
        .clr_i  (stat_clr[gi]),
        .val_o  (stat_val[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (word_idx == 30'd0) begin
      rd_data = ID_VALUE;
    end
    for (int i = 0; i < NCTRL; i++) begin
      if (word_idx == 30'(i + 1)) rd_data = ctrl_q[i];
    end
    for (int i = 0; i < NSTAT; i++) begin
      if (word_idx == 30'(NCTRL + 1 + i)) rd_data = stat_val[i];
    end
    dout_d = rd_en ? rd_data : dout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RST & ~CTRL_PULSE_MASK;
      ctrl_wr_q <= '0;
      dout_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      ctrl_wr_q <= ctrl_wr_d;
      dout_q    <= dout_d;
    end
  end

  assign ctrl_ob    = ctrl_q;
  assign ctrl_wr_ob = ctrl_wr_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_mc_register_bank.sv
// Directed bench for mc_register_bank: a table of single-cycle accesses with
// hand-computed results, plus reset sequences around it.
module tb_mc_register_bank;
  import mc_register_bank_pkg::*;

  localparam reg32_t [3:0] T_CTRL_RST   = {32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_00F1, 32'h1122_3344};
  localparam reg32_t [3:0] T_PULSE_MASK = {32'h0, 32'h0, 32'h0000_0001, 32'h0};
  localparam reg32_t [3:0] T_STICKY     = {32'h0, 32'h0, 32'h0, 32'h0000_00FF};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  ckrs_t        clkrs;
  logic         en = 1'b0;
  logic [31:0]  addr = '0;
  logic [3:0]   we = '0;
  logic [31:0]  din = '0;
  logic [31:0]  dout;
  reg32_t [3:0] ctrl_ob;
  logic [3:0]   ctrl_wr_ob;
  reg32_t [3:0] stat_ib;

  int n_vec = 0;
  int n_fail = 0;

  assign clkrs.clk   = clk;
  assign clkrs.reset = rst_n;

  always #5 clk = ~clk;

  mc_register_bank #(
    .NCTRL            (4),
    .NSTAT            (4),
    .ID_VALUE         (32'h4D43_0001),
    .CTRL_RST         (T_CTRL_RST),
    .CTRL_PULSE_MASK  (T_PULSE_MASK),
    .STAT_STICKY_MASK (T_STICKY)
  ) dut (
    .ClkRs_ix   (clkrs),
    .en         (en),
    .addr       (addr),
    .we         (we),
    .din        (din),
    .dout       (dout),
    .ctrl_ob    (ctrl_ob),
    .ctrl_wr_ob (ctrl_wr_ob),
    .stat_ib    (stat_ib)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] stat0;
    logic [31:0] exp_dout;
    int          cidx;
    logic [31:0] exp_ctrl;
    logic [3:0]  exp_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic e, logic [31:0] a, logic [3:0] w,
                              logic [31:0] d, logic [31:0] s0, logic [31:0] xd,
                              int ci, logic [31:0] xc, logic [3:0] xw);
    vec_t v;
    v.name = name; v.en = e; v.addr = a; v.we = w; v.din = d; v.stat0 = s0;
    v.exp_dout = xd; v.cidx = ci; v.exp_ctrl = xc; v.exp_wr = xw;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic e, logic [31:0] a, logic [3:0] w, logic [31:0] d);
    en = e; addr = a; we = w; din = d;
  endtask

  initial begin
    stat_ib = {32'hA5A5_A5A5, 32'h0, 32'h1234_5678, 32'h0};

    //                name          en  addr   we       din           stat0   dout          ci ctrl          wr
    vecs.push_back(mk("rd_id",      1, 32'h00, 4'h0, 32'h0,        32'h0,   32'h4D43_0001, 0, 32'h1122_3344, 4'h0));
    vecs.push_back(mk("rd_ctrl0",   1, 32'h04, 4'h0, 32'h0,        32'h0,   32'h1122_3344, 0, 32'h1122_3344, 4'h0));
    vecs.push_back(mk("rd_ctrl1",   1, 32'h08, 4'h0, 32'h0,        32'h0,   32'h0000_00F0, 1, 32'h0000_00F0, 4'h0));
    vecs.push_back(mk("wr_bytes",   1, 32'h04, 4'h5, 32'hAABB_CCDD, 32'h0,  32'h0000_00F0, 0, 32'h11BB_33DD, 4'h1));
    vecs.push_back(mk("idle_hold",  0, 32'h04, 4'h0, 32'h0,        32'h0,   32'h0000_00F0, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_lsb_ign", 1, 32'h07, 4'h0, 32'h0,        32'h0,   32'h11BB_33DD, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("pulse_wr",   1, 32'h08, 4'h1, 32'h0000_0001, 32'h0,  32'h11BB_33DD, 1, 32'h0000_0001, 4'h2));
    vecs.push_back(mk("pulse_end",  0, 32'h00, 4'h0, 32'h0,        32'h0,   32'h11BB_33DD, 1, 32'h0000_0000, 4'h0));
    vecs.push_back(mk("pulse_b2b1", 1, 32'h08, 4'h3, 32'h0000_0101, 32'h0,  32'h11BB_33DD, 1, 32'h0000_0101, 4'h2));
    vecs.push_back(mk("pulse_b2b2", 1, 32'h08, 4'h1, 32'h0000_0001, 32'h0,  32'h11BB_33DD, 1, 32'h0000_0101, 4'h2));
    vecs.push_back(mk("pulse_fall", 0, 32'h00, 4'h0, 32'h0,        32'h0,   32'h11BB_33DD, 1, 32'h0000_0100, 4'h0));
    vecs.push_back(mk("wr_id_ign",  1, 32'h00, 4'hF, 32'hFFFF_FFFF, 32'h0,  32'h11BB_33DD, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("wr_unmap",   1, 32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0,  32'h11BB_33DD, 3, 32'h0000_0000, 4'h0));
    vecs.push_back(mk("rd_unmap",   1, 32'h40, 4'h0, 32'h0,        32'h0,   32'h0000_0000, 2, 32'hDEAD_BEEF, 4'h0));
    vecs.push_back(mk("rd_ctrl2",   1, 32'h0C, 4'h0, 32'h0,        32'h0,   32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'h0));
    vecs.push_back(mk("stat_pulse", 0, 32'h00, 4'h0, 32'h0,        32'h05,  32'hDEAD_BEEF, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_sticky",  1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_0005, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("w1c_bit0",   1, 32'h14, 4'h1, 32'h0000_0001, 32'h0,  32'h0000_0005, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_cleared", 1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_0004, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_stat1",   1, 32'h18, 4'h0, 32'h0,        32'h0,   32'h1234_5678, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("wr_stat1",   1, 32'h18, 4'hF, 32'hFFFF_FFFF, 32'h0,  32'h1234_5678, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_stat3",   1, 32'h20, 4'h0, 32'h0,        32'h0,   32'hA5A5_A5A5, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_past_st", 1, 32'h24, 4'h0, 32'h0,        32'h0,   32'h0000_0000, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_live",    1, 32'h14, 4'h0, 32'h0,        32'h300, 32'h0000_0304, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_same_set",1, 32'h14, 4'h0, 32'h0,        32'h08,  32'h0000_0004, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_prev_set",1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("w1c_vs_set", 1, 32'h14, 4'h1, 32'h0000_0004, 32'h04, 32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_set_won", 1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("w1c_nostrb", 1, 32'h14, 4'h2, 32'h0000_000C, 32'h0,  32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_nostrb",  1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("w0_noeff",   1, 32'h14, 4'h1, 32'h0000_0000, 32'h0,  32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("w1c_both",   1, 32'h14, 4'h1, 32'h0000_000C, 32'h0,  32'h0000_000C, 0, 32'h11BB_33DD, 4'h0));
    vecs.push_back(mk("rd_zero",    1, 32'h14, 4'h0, 32'h0,        32'h0,   32'h0000_0000, 0, 32'h11BB_33DD, 4'h0));

    // Reset with a pending read: discarded, dout stays 0 afterwards.
    rst_n = 1'b0;
    set_in(1'b1, 32'h00, 4'h0, 32'h0);
    step();
    step();
    n_vec++;
    check32("rst_dout", dout, 32'h0);
    check32("rst_ctrl0", ctrl_ob[0], 32'h1122_3344);
    check32("rst_ctrl1_pulse0", ctrl_ob[1], 32'h0000_00F0);
    check32("rst_wr", {28'h0, ctrl_wr_ob}, 32'h0);
    rst_n = 1'b1;
    set_in(1'b0, 32'h00, 4'h0, 32'h0);
    step();
    n_vec++;
    check32("rst_read_discarded", dout, 32'h0);

    foreach (vecs[k]) begin
      set_in(vecs[k].en, vecs[k].addr, vecs[k].we, vecs[k].din);
      stat_ib[0] = vecs[k].stat0;
      step();
      n_vec++;
      check32({vecs[k].name, "_dout"}, dout, vecs[k].exp_dout);
      check32({vecs[k].name, "_ctrl"}, ctrl_ob[vecs[k].cidx], vecs[k].exp_ctrl);
      check32({vecs[k].name, "_wr"}, {28'h0, ctrl_wr_ob}, {28'h0, vecs[k].exp_wr});
      $display("vec %0d %s: dout=%08h ctrl[%0d]=%08h wr=%b", k, vecs[k].name, dout,
               vecs[k].cidx, ctrl_ob[vecs[k].cidx], ctrl_wr_ob);
    end

    // Latch a sticky bit, then assert reset during a control write.
    set_in(1'b0, 32'h00, 4'h0, 32'h0);
    stat_ib[0] = 32'h80;
    step();
    stat_ib[0] = 32'h0;
    set_in(1'b1, 32'h04, 4'hF, 32'h5555_5555);
    rst_n = 1'b0;
    step();
    n_vec++;
    check32("rstwr_ctrl0", ctrl_ob[0], 32'h1122_3344);
    check32("rstwr_wr", {28'h0, ctrl_wr_ob}, 32'h0);
    check32("rstwr_dout", dout, 32'h0);
    $display("reset-mid-write: ctrl0=%08h wr=%b dout=%08h", ctrl_ob[0], ctrl_wr_ob, dout);
    rst_n = 1'b1;
    set_in(1'b0, 32'h00, 4'h0, 32'h0);
    step();
    n_vec++;
    check32("rstwr_noffect", ctrl_ob[0], 32'h1122_3344);
    check32("rstwr_nostrobe", {28'h0, ctrl_wr_ob}, 32'h0);
    set_in(1'b1, 32'h14, 4'h0, 32'h0);
    step();
    n_vec++;
    check32("rst_sticky_cleared", dout, 32'h0);
    $display("post-reset sticky read: dout=%08h", dout);
    set_in(1'b0, 32'h00, 4'h0, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
